// File: rtl/sipo_framer.sv
// ============================================================================
// Module   : sipo_framer
// Purpose  : Serial-in/parallel-out framer that assembles WIDTH-bit words from
//            a bit stream and hands them off on a valid/ready output port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_framer #(
   parameter int WIDTH     = 9,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     clear_n,
   input  logic                     flush,
   input  logic                     si,
   input  logic                     si_valid,
   output logic                     si_ready,
   output logic [WIDTH-1:0]         po,
   output logic                     po_valid,
   input  logic                     po_ready,
   output logic [WIDTH-1:0]         sr,
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int                 CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] po_q, po_d;
   logic             po_valid_q, po_valid_d;

   logic [WIDTH-1:0] w_sr_shift;
   logic             w_at_last;
   logic             w_acc;
   logic             w_complete;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_sr_shift = {sr_q[WIDTH-2:0], si};
      end else begin : g_lsb_first
         assign w_sr_shift = {si, sr_q[WIDTH-1:1]};
      end
   endgenerate

   // Only the word-completing bit is held off while the holding register is stalled.
   assign w_at_last  = (cnt_q == LAST_CNT);
   assign si_ready   = ~(po_valid_q & ~po_ready & w_at_last);
   assign w_acc      = si_valid & si_ready;
   assign w_complete = w_acc & w_at_last & ~flush;

   always_comb begin
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      po_d       = po_q;
      po_valid_d = po_valid_q;

      if (flush) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (w_acc) begin
         sr_d  = w_sr_shift;
         cnt_d = w_at_last ? '0 : cnt_q + CNT_W'(1);
      end

      if (w_complete) begin
         po_d       = w_sr_shift;
         po_valid_d = 1'b1;
      end else if (po_valid_q && po_ready) begin
         po_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         sr_q       <= '0;
         cnt_q      <= '0;
         po_q       <= '0;
         po_valid_q <= 1'b0;
      end else begin
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         po_q       <= po_d;
         po_valid_q <= po_valid_d;
      end
   end

   assign po       = po_q;
   assign po_valid = po_valid_q;
   assign sr       = sr_q;
   assign bit_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_framer.sv
// ============================================================================
// Module   : tb_sipo_framer
// Purpose  : Scoreboard bench for sipo_framer, MSB-first and LSB-first copies
//            driven from one shared bit stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_framer;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       flush;
   logic       si;
   logic       si_valid;
   logic       po_ready;

   logic       si_ready_m, si_ready_l;
   logic [8:0] po_m, po_l, sr_m, sr_l;
   logic       po_valid_m, po_valid_l;
   logic [3:0] bit_cnt_m, bit_cnt_l;

   int n_tests = 0;
   int n_fail  = 0;

   logic [8:0] q_m[$];
   logic [8:0] q_l[$];
   logic [8:0] wm, wl, last_m, last_l;
   int         nb;

   always #5 clk = ~clk;

   sipo_framer #(.WIDTH(9), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .clear_n(clear_n), .flush(flush), .si(si), .si_valid(si_valid),
      .si_ready(si_ready_m), .po(po_m), .po_valid(po_valid_m), .po_ready(po_ready),
      .sr(sr_m), .bit_cnt(bit_cnt_m));

   sipo_framer #(.WIDTH(9), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .clear_n(clear_n), .flush(flush), .si(si), .si_valid(si_valid),
      .si_ready(si_ready_l), .po(po_l), .po_valid(po_valid_l), .po_ready(po_ready),
      .sr(sr_l), .bit_cnt(bit_cnt_l));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bench-side word assembly: bit i of a word goes to po[8-i] MSB-first, po[i] LSB-first.
   task automatic model_add(input logic b);
      wm[8-nb] = b;
      wl[nb]   = b;
      nb++;
      if (nb == 9) begin
         q_m.push_back(wm);
         q_l.push_back(wl);
         last_m = wm;
         last_l = wl;
         nb = 0;
         wm = '0;
         wl = '0;
      end
   endtask

   task automatic model_clear_partial();
      nb = 0;
      wm = '0;
      wl = '0;
   endtask

   task automatic send_bit(input logic b);
      int guard = 0;
      si       = b;
      si_valid = 1'b1;
      @(negedge clk);
      while (!si_ready_m && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!si_ready_m) check("si_ready_timeout", 32'(si_ready_m), 32'd1);
      @(posedge clk); #1;
      si_valid = 1'b0;
      si       = 1'b0;
      model_add(b);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Monitor: every word that transfers must match the head of the scoreboard.
   always @(negedge clk) begin
      if (clear_n && po_valid_m && po_ready) begin
         if (q_m.size() == 0) check("po_m_unexpected", 32'(po_m), 32'h1ff00);
         else check("po_m_word", 32'(po_m), 32'(q_m.pop_front()));
      end
      if (clear_n && po_valid_l && po_ready) begin
         if (q_l.size() == 0) check("po_l_unexpected", 32'(po_l), 32'h1ff00);
         else check("po_l_word", 32'(po_l), 32'(q_l.pop_front()));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] t1 [9];
      logic [8:0] ta;
      logic [8:0] tb;
      logic [8:0] exp_sr_m, exp_sr_l;
      logic       rb;

      t1 = '{9'd1, 9'd0, 9'd1, 9'd1, 9'd0, 9'd0, 9'd1, 9'd1, 9'd1};
      ta = 9'b011010010;
      tb = 9'b110001011;
      wm = '0; wl = '0; nb = 0; last_m = '0; last_l = '0;
      clear_n = 1'b0; flush = 1'b0; si = 1'b0; si_valid = 1'b0; po_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_sr_m", 32'(sr_m), 32'd0);
      check("rst_cnt_m", 32'(bit_cnt_m), 32'd0);
      check("rst_po_m", 32'(po_m), 32'd0);
      check("rst_pov_m", 32'(po_valid_m), 32'd0);
      check("rst_po_l", 32'(po_l), 32'd0);
      check("rst_si_ready", 32'(si_ready_m), 32'd1);
      clear_n = 1'b1;
      step();

      // T1/T2: one word, both shift orders, sr and bit_cnt tracked per bit
      exp_sr_m = '0;
      exp_sr_l = '0;
      for (int i = 0; i < 9; i++) begin
         send_bit(t1[i][0]);
         exp_sr_m = {exp_sr_m[7:0], t1[i][0]};
         exp_sr_l = {t1[i][0], exp_sr_l[8:1]};
         check("t1_cnt", 32'(bit_cnt_m), 32'((i + 1) % 9));
         check("t1_sr_m", 32'(sr_m), 32'(exp_sr_m));
         check("t2_sr_l", 32'(sr_l), 32'(exp_sr_l));
         check("t1_pov", 32'(po_valid_m), 32'(i == 8));
      end
      check("t1_po_m", 32'(po_m), 32'h167);
      check("t2_po_l", 32'(po_l), 32'h1cd);
      step();
      check("t1_pov_drop", 32'(po_valid_m), 32'd0);
      check("t1_po_hold", 32'(po_m), 32'h167);

      // T3: stall the output, fill one word plus eight bits of the next
      po_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_bit(ta[8-i]);
      for (int i = 0; i < 8; i++) send_bit(tb[8-i]);
      check("t3_cnt8", 32'(bit_cnt_m), 32'd8);
      check("t3_si_ready_low", 32'(si_ready_m), 32'd0);
      check("t3_pov", 32'(po_valid_m), 32'd1);
      check("t3_po_a", 32'(po_m), 32'(ta));
      si = tb[0];
      si_valid = 1'b1;
      step();
      step();
      check("t3_cnt_held", 32'(bit_cnt_m), 32'd8);
      check("t3_po_stable", 32'(po_m), 32'(ta));
      check("t3_pov_stable", 32'(po_valid_m), 32'd1);
      po_ready = 1'b1;
      model_add(tb[0]);
      step();
      si_valid = 1'b0;
      check("t3_pov_kept", 32'(po_valid_m), 32'd1);
      check("t3_po_b", 32'(po_m), 32'(tb));
      check("t3_cnt0", 32'(bit_cnt_m), 32'd0);
      step();
      check("t3_pov_drop", 32'(po_valid_m), 32'd0);

      // T4: flush with a 6th bit, then a clean word
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      si = 1'b1; si_valid = 1'b1; flush = 1'b1;
      step();
      si_valid = 1'b0; flush = 1'b0;
      model_clear_partial();
      check("t4_cnt", 32'(bit_cnt_m), 32'd0);
      check("t4_sr", 32'(sr_m), 32'd0);
      check("t4_pov", 32'(po_valid_m), 32'd0);
      check("t4_po", 32'(po_m), 32'(last_m));
      for (int i = 0; i < 9; i++) send_bit(1'(i % 3 == 0));
      check("t4_clean_po", 32'(po_m), 32'h124);
      // Flushing the completing bit must not load the holding register
      step();
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      si = 1'b1; si_valid = 1'b1; flush = 1'b1;
      step();
      si_valid = 1'b0; flush = 1'b0;
      model_clear_partial();
      check("t4_flush_last_pov", 32'(po_valid_m), 32'd0);
      check("t4_flush_last_po", 32'(po_m), 32'h124);
      check("t4_flush_last_cnt", 32'(bit_cnt_m), 32'd0);

      // T5: back-to-back random words at full rate
      for (int k = 0; k < 45; k++) begin
         rb = 1'($urandom_range(0, 1));
         si = rb;
         si_valid = 1'b1;
         @(negedge clk);
         check("t5_si_ready", 32'(si_ready_m), 32'd1);
         @(posedge clk); #1;
         model_add(rb);
         check("t5_pov_pulse", 32'(po_valid_m), 32'(k % 9 == 8));
      end
      si_valid = 1'b0;
      step();

      // T6: asynchronous reset mid-word and mid-stall
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      check("t6_cnt4", 32'(bit_cnt_m), 32'd4);
      #2 clear_n = 1'b0;
      #1;
      check("t6a_sr", 32'(sr_m), 32'd0);
      check("t6a_cnt", 32'(bit_cnt_m), 32'd0);
      check("t6a_po", 32'(po_m), 32'd0);
      check("t6a_pov", 32'(po_valid_m), 32'd0);
      clear_n = 1'b1;
      model_clear_partial();
      step();
      po_ready = 1'b0;
      for (int i = 0; i < 11; i++) send_bit(1'b1);
      check("t6_stall_pov", 32'(po_valid_m), 32'd1);
      #2 clear_n = 1'b0;
      #1;
      check("t6b_sr", 32'(sr_m), 32'd0);
      check("t6b_cnt", 32'(bit_cnt_m), 32'd0);
      check("t6b_po", 32'(po_m), 32'd0);
      check("t6b_pov", 32'(po_valid_m), 32'd0);
      check("t6b_po_l", 32'(po_l), 32'd0);
      clear_n = 1'b1;
      q_m.delete();
      q_l.delete();
      model_clear_partial();
      po_ready = 1'b1;
      step();
      for (int i = 0; i < 9; i++) send_bit(1'(i < 2));
      check("t6_after_po", 32'(po_m), 32'h180);
      step();
      step();
      check("sb_empty_m", 32'(q_m.size()), 32'd0);
      check("sb_empty_l", 32'(q_l.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
